// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between N_REQ byte producers.
// Multi-byte messages keep ownership until the byte flagged "last" has been sent.
module uart_tx_arbiter #(
   parameter int N_REQ        = 4,
   parameter int DATA_W       = 8,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic                      clk_50m,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          last,
   input  logic [N_REQ*DATA_W-1:0]   data,
   output logic [N_REQ-1:0]          ack,
   output logic [N_REQ-1:0]          grant,
   output logic [DATA_W-1:0]         uart_din,
   output logic                      uart_wr_en,
   input  logic                      uart_tx_busy,
   output logic                      err_timeout,
   output logic [1:0]                dbg_state,
   output logic                      dbg_lock
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t              r_state;
   logic [N_REQ-1:0]    r_grant;
   logic [PTR_W-1:0]    r_owner;
   logic [PTR_W-1:0]    r_ptr;
   logic                r_lock;
   logic                r_last;
   logic [7:0]          r_cnt;
   logic [DATA_W-1:0]   r_din;

   state_t              w_state_nxt;
   logic [N_REQ-1:0]    w_grant_nxt;
   logic [PTR_W-1:0]    w_owner_nxt;
   logic [PTR_W-1:0]    w_ptr_nxt;
   logic                w_lock_nxt;
   logic                w_last_nxt;
   logic [7:0]          w_cnt_nxt;
   logic [DATA_W-1:0]   w_din_nxt;

   logic                w_found;
   logic [PTR_W-1:0]    w_winner;
   logic [N_REQ-1:0]    w_winner_oh;
   logic [PTR_W-1:0]    w_owner_inc;
   logic [DATA_W-1:0]   w_owner_data;
   logic [7:0]          w_cnt_inc;
   logic                w_timeout;

   function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int off);
      int s;
      s = int'(32'(base)) + off;
      if (s >= N_REQ) s = s - N_REQ;
      return PTR_W'(s);
   endfunction

   // First requester at or after the pointer, wrapping modulo N_REQ.
   always_comb begin
      w_found  = 1'b0;
      w_winner = r_ptr;
      for (int k = 0; k < N_REQ; k++) begin
         if (!w_found && req[rr_index(r_ptr, k)]) begin
            w_found  = 1'b1;
            w_winner = rr_index(r_ptr, k);
         end
      end
   end

   assign w_winner_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
   assign w_owner_inc  = (r_owner == PTR_W'(N_REQ-1)) ? '0 : r_owner + 1'b1;
   assign w_owner_data = data[r_owner*DATA_W +: DATA_W];
   assign w_cnt_inc    = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
   // A busy rise in the expiring cycle wins, so the timeout is gated by !uart_tx_busy.
   assign w_timeout    = (r_state == WAIT_BUSY) && !uart_tx_busy &&
                         (w_cnt_inc >= 8'(BUSY_TIMEOUT));

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_owner_nxt = r_owner;
      w_ptr_nxt   = r_ptr;
      w_lock_nxt  = r_lock;
      w_last_nxt  = r_last;
      w_cnt_nxt   = r_cnt;
      w_din_nxt   = r_din;
      case (r_state)
         IDLE: begin
            w_grant_nxt = '0;
            if (w_found) begin
               w_grant_nxt = w_winner_oh;
               w_owner_nxt = w_winner;
               w_state_nxt = LOAD;
            end
         end
         LOAD: begin
            w_din_nxt   = w_owner_data;
            w_last_nxt  = last[r_owner];
            w_cnt_nxt   = 8'd0;
            w_state_nxt = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (uart_tx_busy) begin
               w_state_nxt = WAIT_DONE;
            end else begin
               w_cnt_nxt = w_cnt_inc;
               if (w_timeout) begin
                  w_lock_nxt  = 1'b0;
                  w_ptr_nxt   = w_owner_inc;
                  w_grant_nxt = '0;
                  w_state_nxt = IDLE;
               end
            end
         end
         WAIT_DONE: begin
            if (!uart_tx_busy) begin
               if (!r_last && req[r_owner]) begin
                  w_lock_nxt  = 1'b1;
                  w_state_nxt = LOAD;
               end else begin
                  // End of message or abandoned message: hand the uart on.
                  w_lock_nxt  = 1'b0;
                  w_ptr_nxt   = w_owner_inc;
                  w_grant_nxt = '0;
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_owner <= '0;
         r_ptr   <= '0;
         r_lock  <= 1'b0;
         r_last  <= 1'b0;
         r_cnt   <= 8'd0;
         r_din   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_owner <= w_owner_nxt;
         r_ptr   <= w_ptr_nxt;
         r_lock  <= w_lock_nxt;
         r_last  <= w_last_nxt;
         r_cnt   <= w_cnt_nxt;
         r_din   <= w_din_nxt;
      end
   end

   // Handshake: ack[i] pulses in the LOAD cycle together with uart_wr_en, and only for the owner.
   assign uart_wr_en  = (r_state == LOAD);
   assign ack         = (r_state == LOAD) ? r_grant : '0;
   assign uart_din    = (r_state == LOAD) ? w_owner_data : r_din;
   assign grant       = r_grant;
   assign err_timeout = w_timeout;
   assign dbg_state   = r_state;
   assign dbg_lock    = r_lock;

endmodule
